// File: rtl/vga_fb_pkg.sv
// Shared framebuffer geometry, VGA timing constants and fetch FSM state type
// for the framebuffer scheduler and its line buffer.
package vga_fb_pkg;
  localparam int FB_W       = 200;
  localparam int FB_H       = 150;
  localparam int SCALE_LOG2 = 2;
  localparam int PIX_W      = 12;
  localparam int ADDR_W     = 15;
  localparam int COL_W      = 8;

  localparam int H_DISPLAY  = 800;
  localparam int V_DISPLAY  = 600;
  localparam int V_MAX      = 665;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fsm_e;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [COL_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(FB_W) + ADDR_W'(col);
  endfunction
endpackage

// File: rtl/vga_line_buffer.sv
// Two-bank scan line buffer: fetch side writes one bank while scan-out reads
// the other; the read port doubles as the registered DAC output.
module vga_line_buffer
  import vga_fb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [COL_W-1:0] wr_col_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic             rd_bank_i,
  input  logic [COL_W-1:0] rd_col_i,
  output logic [PIX_W-1:0] rd_data_o
);
  logic [PIX_W-1:0] mem_q [2][FB_W];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_bank_i][wr_col_i] <= wr_data_i;
  end

  // Disabled reads output black rather than holding the last pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= mem_q[rd_bank_i][rd_col_i];
    else              rd_data_o <= '0;
  end
endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the single-port framebuffer RAM between row prefetch into the
// line buffer (absolute priority) and the pixel write port.
module vga_fb_scheduler
  import vga_fb_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic              video_on,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  rgb,
  output logic              busy,
  output logic              wr_drop,
  output logic              fetch_overrun
);
  localparam logic [10:0] SUB_MASK = 11'((1 << SCALE_LOG2) - 1);

  fsm_e             state_q, state_d;
  logic [10:0]      x_q, y_row;
  logic             ls, trig_hit, trigger, start, issue_fetch;
  logic [COL_W-1:0] trig_row, row_q, col_q, iss_col_q, rd_col_q;
  logic             iss_vld_q, rd_vld_q, frame_valid_q;
  logic             wr_fire, wr_in_range;

  assign y_row = y >> SCALE_LOG2;
  assign ls    = (x == '0) && (x_q != '0);

  always_comb begin
    trig_hit = 1'b0;
    trig_row = '0;
    if (y < 11'(V_DISPLAY) && (y & SUB_MASK) == '0 && (y_row + 11'd1) < 11'(FB_H)) begin
      trig_hit = 1'b1;
      trig_row = COL_W'(y_row + 11'd1);
    end else if (y == 11'(V_MAX)) begin
      trig_hit = 1'b1;
    end
  end

  assign trigger     = ls && trig_hit;
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 8'(FB_H));
  assign wr_fire     = wr_valid && wr_ready;

  always_ff @(posedge clk_100MHz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trigger) state_d = FETCH;
      FETCH:   if (col_q == COL_W'(FB_W)) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column 0 is issued from the trigger cycle so the whole fetch spans FB_W+2 clks.
  always_comb begin
    start       = (state_q == IDLE) && trigger;
    issue_fetch = (state_q == FETCH) && (col_q != COL_W'(FB_W));
    busy        = (state_q != IDLE);
    wr_ready    = (state_q == IDLE) && !trigger && !reset;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      x_q           <= '0;
      row_q         <= '0;
      col_q         <= '0;
      iss_vld_q     <= 1'b0;
      iss_col_q     <= '0;
      rd_vld_q      <= 1'b0;
      rd_col_q      <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      wr_drop       <= 1'b0;
      frame_valid_q <= 1'b0;
      fetch_overrun <= 1'b0;
    end else begin
      x_q       <= x;
      mem_we    <= wr_fire && wr_in_range;
      wr_drop   <= wr_fire && !wr_in_range;
      iss_vld_q <= start || issue_fetch;
      // Read data returns one clk after its address; column follows alongside.
      rd_vld_q  <= iss_vld_q;
      rd_col_q  <= iss_col_q;
      if (start) begin
        row_q     <= trig_row;
        col_q     <= COL_W'(1);
        iss_col_q <= '0;
        mem_addr  <= fb_addr(trig_row, '0);
      end else if (issue_fetch) begin
        col_q     <= col_q + COL_W'(1);
        iss_col_q <= col_q;
        mem_addr  <= fb_addr(row_q, col_q);
      end else if (wr_fire) begin
        mem_addr  <= fb_addr(wr_y, wr_x);
        mem_wdata <= wr_data;
      end
      if (state_q == DRAIN && row_q == '0) frame_valid_q <= 1'b1;
      if (trigger && state_q != IDLE)      fetch_overrun <= 1'b1;
    end
  end

  vga_line_buffer u_lb (
    .clk_i     (clk_100MHz),
    .rst_i     (reset),
    .wr_en_i   (rd_vld_q),
    .wr_bank_i (row_q[0]),
    .wr_col_i  (rd_col_q),
    .wr_data_i (mem_rdata),
    .rd_en_i   (video_on && frame_valid_q),
    .rd_bank_i (y[SCALE_LOG2]),
    .rd_col_i  (COL_W'(x >> SCALE_LOG2)),
    .rd_data_o (rgb)
  );
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a read-only RAM model whose
// contents follow a fixed per-row pattern.
module tb_vga_fb_scheduler;
  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        video_on, wr_valid, wr_ready;
  logic [7:0]  wr_x, wr_y;
  logic [11:0] wr_data, mem_wdata, mem_rdata, rgb;
  logic [14:0] mem_addr;
  logic        mem_we, busy, wr_drop, fetch_overrun;
  int          vecs = 0;
  int          miss = 0;
  int          c, n;

  always #5 clk_100MHz = ~clk_100MHz;

  vga_fb_scheduler dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .x             (x),
    .y             (y),
    .video_on      (video_on),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_data       (wr_data),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .rgb           (rgb),
    .busy          (busy),
    .wr_drop       (wr_drop),
    .fetch_overrun (fetch_overrun)
  );

  // Row 0 red, row 1 green, other rows {row[3:0], col}.
  function automatic logic [11:0] pix(input int r, input int cc);
    logic [3:0] rl;
    logic [7:0] cl;
    if (r == 0) return 12'hF00;
    if (r == 1) return 12'h0F0;
    rl = r[3:0];
    cl = cc[7:0];
    return {rl, cl};
  endfunction

  always @(posedge clk_100MHz)
    mem_rdata <= pix(int'(mem_addr) / 200, int'(mem_addr) % 200);

  task automatic step();
    @(negedge clk_100MHz);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scan_line(input int yv);
    for (int v = 0; v < 800; v++) begin
      y = 11'(yv); x = 11'(v); video_on = 1'b1;
      step();
      chk($sformatf("scan y%0d x%0d", yv, v), 32'(rgb), 32'(pix(yv >> 2, v >> 2)));
    end
    x = 11'd800; video_on = 1'b0;
    step();
    chk("scan blank", 32'(rgb), 0);
  endtask

  initial begin
    reset = 1'b1; x = 11'd5; y = '0; video_on = 1'b0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    step(); step();
    chk("rst busy", 32'(busy), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst rgb", 32'(rgb), 0);
    chk("rst wr_ready", 32'(wr_ready), 0);
    chk("rst wr_drop", 32'(wr_drop), 0);
    chk("rst overrun", 32'(fetch_overrun), 0);
    reset = 1'b0;
    step();

    // Row-0 fetch at y=V_MAX; screen stays black until it completes
    y = 11'd665; x = 11'd0; #1;
    chk("t1 wr_ready on trigger", 32'(wr_ready), 0);
    step(); x = 11'd1; video_on = 1'b1;
    chk("t1 busy c1", 32'(busy), 1);
    chk("t1 addr c1", 32'(mem_addr), 0);
    for (int k = 2; k <= 202; k++) begin
      step();
      if (k == 150) chk("t1 rgb black", 32'(rgb), 0);
      if (k == 200) chk("t1 addr c200", 32'(mem_addr), 199);
      if (k == 201) chk("t1 busy c201", 32'(busy), 1);
    end
    chk("t1 busy c202", 32'(busy), 0);
    chk("t1 rgb c202", 32'(rgb), 0);
    step();
    chk("t1 frame_valid rgb", 32'(rgb), 32'(12'hF00));
    video_on = 1'b0;

    // Scan-out of rows 0,0,1,2 while later rows prefetch
    scan_line(0);
    scan_line(3);
    scan_line(4);
    scan_line(8);

    // Write held off by a fetch
    y = 11'd12; x = 11'd0; wr_valid = 1'b1; wr_x = 8'd5; wr_y = 8'd7; wr_data = 12'hABC; #1;
    chk("t3 wr_ready on trigger", 32'(wr_ready), 0);
    step(); x = 11'd1; n = 1;
    while (wr_ready !== 1'b1 && n < 400) begin step(); n++; end
    chk("t3 stall clks", n, 202);
    chk("t3 no early we", 32'(mem_we), 0);
    step(); wr_valid = 1'b0;
    chk("t3 mem_we", 32'(mem_we), 1);
    chk("t3 mem_addr", 32'(mem_addr), 1405);
    chk("t3 mem_wdata", 32'(mem_wdata), 32'(12'hABC));
    step();
    chk("t3 we pulse", 32'(mem_we), 0);

    // Range check boundaries
    wr_valid = 1'b1; wr_x = 8'd200; wr_y = 8'd0; wr_data = 12'h123; #1;
    chk("t4 wr_ready idle", 32'(wr_ready), 1);
    step();
    chk("t4 drop x200", 32'(wr_drop), 1);
    chk("t4 we x200", 32'(mem_we), 0);
    wr_x = 8'd199; wr_y = 8'd149; wr_data = 12'h456;
    step();
    chk("t4 drop corner", 32'(wr_drop), 0);
    chk("t4 we corner", 32'(mem_we), 1);
    chk("t4 addr corner", 32'(mem_addr), 29999);
    chk("t4 data corner", 32'(mem_wdata), 32'(12'h456));
    wr_x = 8'd0; wr_y = 8'd150;
    step();
    chk("t4 drop y150", 32'(wr_drop), 1);
    chk("t4 we y150", 32'(mem_we), 0);
    wr_valid = 1'b0;
    step();
    chk("t4 drop pulse", 32'(wr_drop), 0);

    // Trigger while busy
    y = 11'd8; x = 11'd0;
    step(); x = 11'd1; c = 1;
    while (c < 50) begin step(); c++; end
    x = 11'd0; y = 11'd4;
    step(); c++; x = 11'd1;
    chk("t6 overrun set", 32'(fetch_overrun), 1);
    while (c < 101) begin step(); c++; end
    chk("t6 row kept", 32'(mem_addr), 700);
    while (c < 201) begin step(); c++; end
    chk("t6 busy c201", 32'(busy), 1);
    step();
    chk("t6 busy c202", 32'(busy), 0);
    for (int k = 0; k < 5; k++) step();
    chk("t6 overrun sticky", 32'(fetch_overrun), 1);

    // Reset in the middle of a fetch
    y = 11'd0; x = 11'd0;
    step(); x = 11'd1; c = 1;
    while (c < 101) begin step(); c++; end
    chk("t5 addr col100", 32'(mem_addr), 300);
    reset = 1'b1;
    step();
    chk("t5 busy", 32'(busy), 0);
    chk("t5 mem_we", 32'(mem_we), 0);
    chk("t5 mem_addr", 32'(mem_addr), 0);
    chk("t5 rgb", 32'(rgb), 0);
    chk("t5 overrun cleared", 32'(fetch_overrun), 0);
    reset = 1'b0; x = 11'd8; video_on = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("t5 no resume", 32'(busy), 0);
    chk("t5 black after reset", 32'(rgb), 0);
    y = 11'd665; x = 11'd0; video_on = 1'b0;
    step(); x = 11'd1; n = 1;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    chk("t5 refetch clks", n, 202);
    y = 11'd0; x = 11'd8; video_on = 1'b1;
    step();
    chk("t5 visible again", 32'(rgb), 32'(12'hF00));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
